// File: rtl/key_counter_bank_pkg.sv
// Shared types and board-wide constants for the key counter bank.
// Key polarity, default debounce length (~10 ms at 50 MHz) and default prescaler width.
package key_counter_bank_pkg;

  localparam bit KEY_ACTIVE_LOW = 1'b1;
  localparam int DEF_DB_CYCLES  = 500000;
  localparam int DEF_PRESC_W    = 24;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_e;

  // Free-run overrides the keys; simultaneous up/down presses cancel out.
  function automatic step_e step_sel(logic free_run, logic tick, logic up, logic dn);
    if (free_run)       return tick ? STEP_UP : STEP_NONE;
    if (up && !dn)      return STEP_UP;
    if (dn && !up)      return STEP_DN;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/key_counter_bank_if.sv
// Key inputs, free-run control and counter outputs of the key counter bank.
interface key_counter_bank_if #(
  parameter int N_CH = 2,
  parameter int W    = 4
);
  logic [N_CH-1:0]   key_up_n;
  logic [N_CH-1:0]   key_dn_n;
  logic              free_run;
  logic [N_CH*W-1:0] cnt;
  logic [N_CH-1:0]   wrap_pulse;

  modport master (output key_up_n, key_dn_n, free_run, input cnt, wrap_pulse);
  modport slave  (input key_up_n, key_dn_n, free_run, output cnt, wrap_pulse);
endinterface

// File: rtl/key_counter_bank_debounce.sv
// One raw key: 2-flop synchroniser, stable-count debouncer and registered press pulse.
module key_debounce
  import key_counter_bank_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int         DCW     = $clog2(DB_CYCLES) + 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);
  localparam logic       IDLE    = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]     sync_q, sync_d;
  logic [DCW-1:0] dc_q, dc_d;
  logic           lvl_q, lvl_d;
  logic           lvl_prev_q, lvl_prev_d;
  logic           press_q, press_d;

  always_comb begin
    sync_d     = {sync_q[0], key_n};
    lvl_d      = lvl_q;
    dc_d       = dc_q;
    if (sync_q[1] == lvl_q) begin
      dc_d = '0;
    end else if (dc_q != DB_LAST) begin
      dc_d = dc_q + DCW'(1);
    end else begin
      lvl_d = sync_q[1];
      dc_d  = '0;
    end
    lvl_prev_d = lvl_q;
    // Only the idle->active edge counts; release is ignored.
    press_d    = (lvl_prev_q == IDLE) && (lvl_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {2{IDLE}};
      dc_q       <= '0;
      lvl_q      <= IDLE;
      lvl_prev_q <= IDLE;
      press_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      dc_q       <= dc_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/key_counter_bank.sv
// Bank of independent up/down counters stepped by debounced key presses or,
// in free-run mode, by a shared prescaler tick.
module key_counter_bank
  import key_counter_bank_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int W         = 4,
  parameter int DB_CYCLES = 4,
  parameter int PRESC_W   = DEF_PRESC_W,
  parameter bit SATURATE  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  key_counter_bank_if.slave bus
);
  logic [PRESC_W-1:0]       presc_q, presc_d;
  logic                     tick;
  logic [N_CH-1:0]          up_evt, dn_evt, wrap_all;
  logic [N_CH-1:0][W-1:0]   cnt_all;

  // Prescaler free-runs even when free_run is low and wraps naturally.
  always_comb presc_d = presc_q + PRESC_W'(1);
  assign tick = &presc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    step_e        step;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_up (
      .clk(clk), .reset(reset), .key_n(bus.key_up_n[i]), .press(up_evt[i]));
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn (
      .clk(clk), .reset(reset), .key_n(bus.key_dn_n[i]), .press(dn_evt[i]));

    assign step = step_sel(bus.free_run, tick, up_evt[i], dn_evt[i]);

    // A step past either bound pulses wrap; SATURATE picks wrap vs. hold.
    always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      case (step)
        STEP_UP: begin
          if (cnt_q == '1) begin
            wrap_d = 1'b1;
            cnt_d  = SATURATE ? cnt_q : '0;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        STEP_DN: begin
          if (cnt_q == '0) begin
            wrap_d = 1'b1;
            cnt_d  = SATURATE ? cnt_q : '1;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        wrap_q <= wrap_d;
      end
    end

    assign cnt_all[i]  = cnt_q;
    assign wrap_all[i] = wrap_q;
  end

  assign bus.cnt        = cnt_all;
  assign bus.wrap_pulse = wrap_all;
endmodule

// File: tb/tb_key_counter_bank.sv
// Directed bench for key_counter_bank: a wrapping instance and a saturating instance share stimulus.
module tb_key_counter_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] key_up_n = 2'b11;
  logic [1:0] key_dn_n = 2'b11;
  logic       free_run = 1'b0;

  int total = 0;
  int bad   = 0;
  int wp_a0 = 0, wp_a1 = 0, wp_b0 = 0, wp_both = 0;

  always #5 clk = ~clk;

  key_counter_bank_if #(.N_CH(2), .W(4)) bus_a ();
  key_counter_bank_if #(.N_CH(2), .W(4)) bus_b ();

  assign bus_a.key_up_n = key_up_n;
  assign bus_a.key_dn_n = key_dn_n;
  assign bus_a.free_run = free_run;
  assign bus_b.key_up_n = key_up_n;
  assign bus_b.key_dn_n = key_dn_n;
  assign bus_b.free_run = free_run;

  key_counter_bank #(.N_CH(2), .W(4), .DB_CYCLES(4), .PRESC_W(3), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  key_counter_bank #(.N_CH(2), .W(4), .DB_CYCLES(4), .PRESC_W(3), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  task automatic step();
    @(posedge clk);
    #1;
    if (bus_a.wrap_pulse[0]) wp_a0++;
    if (bus_a.wrap_pulse[1]) wp_a1++;
    if (bus_b.wrap_pulse[0]) wp_b0++;
    if (bus_a.wrap_pulse == 2'b11) wp_both++;
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    key_up_n = 2'b11;
    key_dn_n = 2'b11;
    free_run = 1'b0;
    reset    = 1'b1;
    steps(2);
    reset    = 1'b0;
    steps(1);
    wp_a0 = 0; wp_a1 = 0; wp_b0 = 0; wp_both = 0;
  endtask

  // Hold the selected keys long enough to register, then release long enough to settle.
  task automatic press(logic [1:0] up, logic [1:0] dn);
    key_up_n = ~up;
    key_dn_n = ~dn;
    steps(10);
    key_up_n = 2'b11;
    key_dn_n = 2'b11;
    steps(10);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus_a.cnt !== 8'h00 || bus_a.wrap_pulse !== 2'b00) begin
      bad++; $display("FAIL reset_state cnt=%h wrap=%b exp cnt=00 wrap=00", bus_a.cnt, bus_a.wrap_pulse);
    end
    press(2'b01, 2'b00);
    total++;
    if (bus_a.cnt !== 8'h01) begin
      bad++; $display("FAIL reset_pre_press cnt=%h exp=01", bus_a.cnt);
    end
    key_up_n = 2'b10;
    steps(3);
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus_a.cnt !== 8'h00 || bus_a.wrap_pulse !== 2'b00) begin
      bad++; $display("FAIL reset_async cnt=%h wrap=%b exp cnt=00 wrap=00", bus_a.cnt, bus_a.wrap_pulse);
    end
    key_up_n = 2'b11;
    steps(3);
    reset = 1'b0;
    steps(20);
    total++;
    if (bus_a.cnt !== 8'h00 || wp_a0 !== 0) begin
      bad++; $display("FAIL reset_release cnt=%h pulses=%0d exp cnt=00 pulses=0", bus_a.cnt, wp_a0);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    key_up_n = 2'b10;
    steps(7);
    total++;
    if (bus_a.cnt !== 8'h00) begin
      bad++; $display("FAIL press_early cnt=%h exp=00", bus_a.cnt);
    end
    step();
    total++;
    if (bus_a.cnt !== 8'h01) begin
      bad++; $display("FAIL press_latency cnt=%h exp=01", bus_a.cnt);
    end
    steps(12);
    total++;
    if (bus_a.cnt !== 8'h01) begin
      bad++; $display("FAIL press_held cnt=%h exp=01", bus_a.cnt);
    end
    key_up_n = 2'b11;
    steps(10);
    total++;
    if (bus_a.cnt !== 8'h01) begin
      bad++; $display("FAIL press_release cnt=%h exp=01", bus_a.cnt);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    key_dn_n = 2'b01; steps(3);
    key_dn_n = 2'b11; steps(1);
    key_dn_n = 2'b01; steps(3);
    key_dn_n = 2'b11; steps(15);
    total++;
    if (bus_a.cnt !== 8'h00 || wp_a1 !== 0) begin
      bad++; $display("FAIL bounce cnt=%h pulses=%0d exp cnt=00 pulses=0", bus_a.cnt, wp_a1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (15) press(2'b01, 2'b00);
    total++;
    if (bus_a.cnt !== 8'h0F || wp_a0 !== 0) begin
      bad++; $display("FAIL wrap_15 cnt=%h pulses=%0d exp cnt=0f pulses=0", bus_a.cnt, wp_a0);
    end
    press(2'b01, 2'b00);
    total++;
    if (bus_a.cnt !== 8'h00 || wp_a0 !== 1) begin
      bad++; $display("FAIL wrap_16 cnt=%h pulses=%0d exp cnt=00 pulses=1", bus_a.cnt, wp_a0);
    end
    press(2'b00, 2'b01);
    total++;
    if (bus_a.cnt !== 8'h0F || wp_a0 !== 2) begin
      bad++; $display("FAIL wrap_down cnt=%h pulses=%0d exp cnt=0f pulses=2", bus_a.cnt, wp_a0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (15) press(2'b01, 2'b00);
    total++;
    if (bus_b.cnt !== 8'h0F || wp_b0 !== 0) begin
      bad++; $display("FAIL sat_15 cnt=%h pulses=%0d exp cnt=0f pulses=0", bus_b.cnt, wp_b0);
    end
    press(2'b01, 2'b00);
    total++;
    if (bus_b.cnt !== 8'h0F || wp_b0 !== 1) begin
      bad++; $display("FAIL sat_16 cnt=%h pulses=%0d exp cnt=0f pulses=1", bus_b.cnt, wp_b0);
    end
    press(2'b01, 2'b00);
    total++;
    if (bus_b.cnt !== 8'h0F || wp_b0 !== 2) begin
      bad++; $display("FAIL sat_17 cnt=%h pulses=%0d exp cnt=0f pulses=2", bus_b.cnt, wp_b0);
    end
    do_reset();
    press(2'b00, 2'b01);
    total++;
    if (bus_b.cnt !== 8'h00 || wp_b0 !== 1) begin
      bad++; $display("FAIL sat_down cnt=%h pulses=%0d exp cnt=00 pulses=1", bus_b.cnt, wp_b0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(2'b01, 2'b01);
    total++;
    if (bus_a.cnt !== 8'h00 || wp_a0 !== 0) begin
      bad++; $display("FAIL simul_same cnt=%h pulses=%0d exp cnt=00 pulses=0", bus_a.cnt, wp_a0);
    end
    press(2'b01, 2'b10);
    total++;
    if (bus_a.cnt !== 8'hF1 || wp_a1 !== 1 || wp_a0 !== 0) begin
      bad++; $display("FAIL simul_cross cnt=%h p0=%0d p1=%0d exp cnt=f1 p0=0 p1=1",
                      bus_a.cnt, wp_a0, wp_a1);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    free_run = 1'b1;
    // 64 cycles span exactly 8 ticks whatever the prescaler phase; presses must be ignored.
    press(2'b01, 2'b00);
    press(2'b00, 2'b10);
    press(2'b11, 2'b00);
    steps(4);
    total++;
    if (bus_a.cnt !== 8'h88) begin
      bad++; $display("FAIL free_8 cnt=%h exp=88", bus_a.cnt);
    end
    steps(64);
    total++;
    if (bus_a.cnt !== 8'h00 || wp_both !== 1) begin
      bad++; $display("FAIL free_wrap cnt=%h both_pulses=%0d exp cnt=00 both_pulses=1", bus_a.cnt, wp_both);
    end
    steps(24);
    total++;
    if (bus_a.cnt !== 8'h33) begin
      bad++; $display("FAIL free_3 cnt=%h exp=33", bus_a.cnt);
    end
    free_run = 1'b0;
    steps(30);
    total++;
    if (bus_a.cnt !== 8'h33) begin
      bad++; $display("FAIL free_off_hold cnt=%h exp=33", bus_a.cnt);
    end
    press(2'b10, 2'b00);
    total++;
    if (bus_a.cnt !== 8'h43) begin
      bad++; $display("FAIL free_off_press cnt=%h exp=43", bus_a.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_saturate();
    test_simultaneous();
    test_free_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
